mpsk_qam_mod_stream: RTL
========================

Name: mpsk_qam_mod_stream

Overview:
Streaming baseband modulator. It is the parametrised successor to the team's fixed 2-bit QPSK mapper.
- Accepts a serial bit stream on a valid/ready handshake and packs 1, 2 or 4 bits per symbol according to a run-time mode (BPSK / QPSK / 16-QAM).
- Gray-maps each symbol to signed I/Q and presents it on a registered valid/ready output.
- Sits between the framer/scrambler and the pulse-shaping filter.

Parameters:
OUT_W, 7, signed width of out_re/out_im (min 4).
AMP, 45, BPSK/QPSK axis magnitude; must be ≤ 2^(OUT_W-1)-1.
QAM_HI, 57, 16-QAM outer level magnitude.
QAM_LO, 19, 16-QAM inner level magnitude.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
mode  in  2  0=BPSK, 1=QPSK, 2=16-QAM, 3=reserved (treated as QPSK).
in_bit  in  1  serial data bit.
in_valid  in  1  in_bit valid.
in_ready  out  1  block accepts in_bit this cycle.
out_re  out  OUT_W  signed in-phase sample.
out_im  out  OUT_W  signed quadrature sample.
out_valid  out  1  symbol valid.
out_ready  in  1  downstream accepts symbol.

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_re=0, out_im=0, bit counter=0, shift register=0, latched mode=QPSK. Reset mid-symbol discards the partial bits and any held output symbol.
- Bits per symbol N: BPSK=1, QPSK=2, 16QAM=4.
- Mode latching: mode is sampled when the first bit of a symbol is accepted (counter=0). Changes during a partial symbol are ignored until the next symbol.
- Bit order: the first bit accepted is b0, then b1, b2, b3.
- Input transfer occurs when in_valid && in_ready.
- in_ready = !out_valid || out_ready. It is combinational from out_ready; no dependency on in_valid.
- State machine:
  - COLLECT: counter increments on each transfer.
  - On the transfer of bit N-1, the mapped symbol is registered into the output on the same clock edge, out_valid is set, and the counter returns to 0.
  - Latency: final bit accepted at edge k, so out_valid=1 from edge k.
  - Output hold: out_valid, out_re and out_im hold stable until out_valid && out_ready.
  - Simultaneous events: a symbol consumed and a new final bit accepted in the same cycle load the new symbol with out_valid kept at 1. This gives full throughput of one symbol per N cycles.
- Mapping (sign bit s: 0→+, 1→−):
  - BPSK: re = b0 ? −AMP : +AMP; im = 0.
  - QPSK: re = b1 ? −AMP : +AMP; im = b0 ? −AMP : +AMP.
  - 16QAM: im uses sign b0, magnitude bit b1; re uses sign b2, magnitude bit b3. Magnitude bit 0→QAM_HI, 1→QAM_LO. Gray order along each axis: −HI(10), −LO(11), +LO(01), +HI(00).
- Arithmetic: negation is two's complement at OUT_W. Parameters are checked by an elaboration-time assertion so no value overflows OUT_W.

Optional Feature:
Macro DIFF_ENC_EN.
- Defined: differential encoding for BPSK/QPSK.
  - A 2-bit phase register p (reset 0) selects the output point. Points, counter-clockwise: p=0 (+A,+A), 1 (−A,+A), 2 (−A,−A), 3 (+A,−A).
  - QPSK increment from {b1,b0}: 00→0, 01→1, 11→2, 10→3.
  - BPSK increment: b0 ? 2 : 0, and re = (p==0) ? +AMP : −AMP, im = 0.
  - p updates only when a symbol is loaded into the output register.
  - 16-QAM bypasses differential encoding and leaves p unchanged.
  - p persists across mode changes and resets only on reset.
- Undefined: absolute mapping as above; no p register is synthesised.

Decomposition:
- Package mod_pkg: mode encoding constants (MODE_BPSK/QPSK/QAM16), bits-per-mode function, default AMP/QAM_HI/QAM_LO.
- Sub-module mpsk_qam_mapper: combinational, takes (mode, bits[3:0], optional p) and returns re/im.
- Top level holds the counter, shift register, output register and handshake.

Test Plan:
- QPSK, out_ready=1, bits 0,0 / 0,1 / 1,0 / 1,1:
  - Expected outputs: (45,45), (−45,45), (45,−45), (−45,−45), i.e. 0101101 / 1010011 in 7-bit.
  - Each out_valid pulse appears on the edge after the second bit.
- BPSK, bits 0,1,1: outputs (45,0), (−45,0), (−45,0) on consecutive cycles, out_valid high continuously.
- 16-QAM, bits b0..b3 = 0,0,0,0 then 1,1,1,1 then 0,1,1,0:
  - Expected outputs: (57,57), (−19,−19), (−57,19).
- Back-pressure: hold out_ready=0 after the first QPSK symbol.
  - in_ready drops once out_valid=1; the symbol is held stable for 5 cycles.
  - Release out_ready: the next symbol is emitted with no bit lost.
- Reset mid-symbol: QPSK bit 1 accepted, then reset asserted for one cycle.
  - out_valid=0, out_re=out_im=0.
  - Next bits 0,0 give (45,45), proving the partial bit was discarded.
  - Switching mode 1→2 mid-symbol takes no effect until the next symbol.
- DIFF_ENC_EN, QPSK, dibits {b1,b0} = 00, 01, 01, 11:
  - p sequence 0, 1, 2, 0.
  - Outputs (45,45), (−45,45), (−45,−45), (45,45).

Source files
------------

// File: rtl/mod_pkg.sv
// rtl/mod_pkg.sv - mode encodings, default levels and mode helpers for the BPSK/QPSK/16-QAM modulator
package mod_pkg;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_QAM16 = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    localparam int DEF_AMP    = 45;
    localparam int DEF_QAM_HI = 57;
    localparam int DEF_QAM_LO = 19;

    function automatic logic [2:0] bits_per_mode(input mode_e m);
        case (m)
            MODE_BPSK:  return 3'd1;
            MODE_QAM16: return 3'd4;
            default:    return 3'd2;
        endcase
    endfunction

    // The reserved encoding behaves as QPSK everywhere downstream.
    function automatic mode_e norm_mode(input logic [1:0] m);
        if (m == 2'd3) begin
            return MODE_QPSK;
        end
        return mode_e'(m);
    endfunction

endpackage

// File: rtl/mpsk_qam_mapper.sv
// rtl/mpsk_qam_mapper.sv - combinational Gray mapper from packed bits to signed I/Q (DIFF_ENC_EN adds phase input)
module mpsk_qam_mapper
    import mod_pkg::*;
#(
    parameter int OUT_W  = 7,
    parameter int AMP    = DEF_AMP,
    parameter int QAM_HI = DEF_QAM_HI,
    parameter int QAM_LO = DEF_QAM_LO
) (
    input  logic [1:0]              mode,
    input  logic [3:0]              bits,
`ifdef DIFF_ENC_EN
    input  logic [1:0]              p,
    output logic [1:0]              p_next,
`endif
    output logic signed [OUT_W-1:0] re,
    output logic signed [OUT_W-1:0] im
);

    localparam logic signed [OUT_W-1:0] A_POS  = OUT_W'(AMP);
    localparam logic signed [OUT_W-1:0] A_NEG  = -A_POS;
    localparam logic signed [OUT_W-1:0] HI_POS = OUT_W'(QAM_HI);
    localparam logic signed [OUT_W-1:0] LO_POS = OUT_W'(QAM_LO);

    // One 16-QAM axis: s picks the sign, m picks inner (1) or outer (0) level.
    function automatic logic signed [OUT_W-1:0] axis_level(input logic s, input logic m);
        logic signed [OUT_W-1:0] mag;
        mag = m ? LO_POS : HI_POS;
        return s ? -mag : mag;
    endfunction

    always_comb begin
        re = '0;
        im = '0;
`ifdef DIFF_ENC_EN
        p_next = p;
`endif
        case (mode_e'(mode))
            MODE_BPSK: begin
`ifdef DIFF_ENC_EN
                p_next = p + (bits[0] ? 2'd2 : 2'd0);
                re     = (p_next == 2'd0) ? A_POS : A_NEG;
`else
                re = bits[0] ? A_NEG : A_POS;
`endif
            end
            MODE_QAM16: begin
                im = axis_level(bits[0], bits[1]);
                re = axis_level(bits[2], bits[3]);
            end
            default: begin
`ifdef DIFF_ENC_EN
                // Gray dibit to phase step: 00->0, 01->1, 11->2, 10->3.
                p_next = p + {bits[1], bits[1] ^ bits[0]};
                case (p_next)
                    2'd0:    begin re = A_POS; im = A_POS; end
                    2'd1:    begin re = A_NEG; im = A_POS; end
                    2'd2:    begin re = A_NEG; im = A_NEG; end
                    default: begin re = A_POS; im = A_NEG; end
                endcase
`else
                re = bits[1] ? A_NEG : A_POS;
                im = bits[0] ? A_NEG : A_POS;
`endif
            end
        endcase
    end

endmodule

// File: rtl/mpsk_qam_mod_stream.sv
// rtl/mpsk_qam_mod_stream.sv - streaming bit-to-symbol modulator with handshakes (optional DIFF_ENC_EN differential encoding)
module mpsk_qam_mod_stream
    import mod_pkg::*;
#(
    parameter int OUT_W  = 7,
    parameter int AMP    = DEF_AMP,
    parameter int QAM_HI = DEF_QAM_HI,
    parameter int QAM_LO = DEF_QAM_LO
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic                    in_bit,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_re,
    output logic signed [OUT_W-1:0] out_im,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int MAX_MAG = (2 ** (OUT_W - 1)) - 1;

    if (OUT_W < 4 || AMP < 0 || AMP > MAX_MAG || QAM_HI < 0 || QAM_HI > MAX_MAG
        || QAM_LO < 0 || QAM_LO > MAX_MAG) begin : g_bad_params
        $error("mpsk_qam_mod_stream: level parameters do not fit OUT_W");
    end

    logic [1:0]              cnt;
    logic [3:0]              shreg;
    mode_e                   mode_q;
    mode_e                   eff_mode;
    logic [3:0]              bits_next;
    logic                    is_last;
    logic                    xfer;
    logic signed [OUT_W-1:0] map_re;
    logic signed [OUT_W-1:0] map_im;
`ifdef DIFF_ENC_EN
    logic [1:0]              p_q;
    logic [1:0]              p_next;
`endif

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;

    // Mode is taken live on the first bit of a symbol and from the latch afterwards.
    always_comb begin
        eff_mode       = (cnt == 2'd0) ? norm_mode(mode) : mode_q;
        bits_next      = shreg;
        bits_next[cnt] = in_bit;
        is_last        = ({1'b0, cnt} == (bits_per_mode(eff_mode) - 3'd1));
    end

    mpsk_qam_mapper #(
        .OUT_W  (OUT_W),
        .AMP    (AMP),
        .QAM_HI (QAM_HI),
        .QAM_LO (QAM_LO)
    ) u_mapper (
        .mode   (eff_mode),
        .bits   (bits_next),
`ifdef DIFF_ENC_EN
        .p      (p_q),
        .p_next (p_next),
`endif
        .re     (map_re),
        .im     (map_im)
    );

    // A load in the same cycle as a consume keeps out_valid high (last assignment wins).
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 2'd0;
            shreg     <= 4'd0;
            mode_q    <= MODE_QPSK;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
`ifdef DIFF_ENC_EN
            p_q       <= 2'd0;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (xfer) begin
                if (cnt == 2'd0) begin
                    mode_q <= eff_mode;
                end
                if (is_last) begin
                    cnt       <= 2'd0;
                    shreg     <= 4'd0;
                    out_re    <= map_re;
                    out_im    <= map_im;
                    out_valid <= 1'b1;
`ifdef DIFF_ENC_EN
                    p_q       <= p_next;
`endif
                end else begin
                    cnt   <= cnt + 2'd1;
                    shreg <= bits_next;
                end
            end
        end
    end

endmodule
